hash_bucket_seq: RTL and testbench
==================================

# hash_bucket_seq

Sequencer that serialises counting-Bloom-filter lookup, increment and decrement operations onto a single-port counter memory. It computes `NoHashes` bucket indices per operation with internal `sub_per_hash` instances (one per seed). It then walks the buckets one at a time, issuing read-modify-write accesses. It sits between a request/response client and an external `2**HashWidth x CntWidth` counter SRAM.

## Interface
- `DataWidth`, 32'd11: width of the key to hash.
- `HashWidth`, 32'd5: bucket index width; the memory has `2**HashWidth` entries.
- `NoHashes`, 32'd3: number of hash functions, each with its own `sub_per_hash` instance.
- `NoRounds`, 32'd1: `sub_per_hash` rounds.
- `CntWidth`, 32'd4: counter width.
- `Seeds`, `cb_filter_pkg::cb_seed_t [NoHashes-1:0]`, default the three team seeds `{299034753,4094834}`, `{19921030,995713}`, `{294388,65146511}`: per-hash PermuteSeed/XorSeed.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_op_i`  in  2  operation: 2'b00 lookup, 2'b01 increment, 2'b10 decrement, 2'b11 treated as lookup.
- `req_data_i`  in  DataWidth  key.
- `resp_valid_o`  out  1  response valid.
- `resp_ready_i`  in  1  response accepted.
- `resp_hit_o`  out  1  all addressed counters were nonzero before this operation.
- `resp_sat_o`  out  1  at least one counter clipped (increment at max, or decrement at 0).
- `mem_req_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  write enable.
- `mem_addr_o`  out  HashWidth  bucket address.
- `mem_wdata_o`  out  CntWidth  write data.
- `mem_rdata_i`  in  CntWidth  read data, valid exactly 1 cycle after a read strobe. The memory always grants.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, READ, MODIFY, RESP.
- **IDLE**
  - `req_ready_o` = 1.
  - On handshake, register the op and all `NoHashes` hash outputs (computed combinationally from `req_data_i`).
  - Clear the index counter k to 0, set the hit flag to 1 and the sat flag to 0, then go to READ.
- **READ**
  - Drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=hash_q[k], then go to MODIFY.
- **MODIFY** (`mem_rdata_i` is valid this cycle)
  - Update the hit flag: hit &= (`mem_rdata_i` != 0).
  - Increment: write `mem_rdata_i`+1 to hash_q[k] in this same cycle. If `mem_rdata_i` == 2**CntWidth-1, write the value unchanged and set sat.
  - Decrement: write `mem_rdata_i`-1. If `mem_rdata_i` == 0, write 0 and set sat.
  - Lookup: `mem_req_o`=0, no write.
  - If k == NoHashes-1, go to RESP. Otherwise increment k and go to READ.
- **RESP**
  - `resp_valid_o`=1; `resp_hit_o` and `resp_sat_o` show the final flags and are held stable.
  - On `resp_ready_i`, go to IDLE. No request is accepted in RESP.
- **Duplicate indices:** if two hashes map to the same bucket, that bucket is processed once per occurrence. Its counter changes by 2, and the second read sees the first write. Increment and decrement stay symmetric.
- **Arithmetic:** all arithmetic is CntWidth-bit unsigned with explicit saturation; it never wraps.
- **Reset mid-operation:** the operation is abandoned with no response. Counters already written stay modified; this is the client's responsibility.

## Timing
- Reset values:
  - `req_ready_o`=1 (FSM in IDLE).
  - `resp_valid_o`, `resp_hit_o`, `resp_sat_o`, `mem_req_o`, `mem_we_o`, `busy_o` all 0.
  - `mem_addr_o` and `mem_wdata_o` = 0.
- With the request handshake at cycle 0:
  - Memory activity occupies cycles 1..2·NoHashes: READ on odd cycles, MODIFY on even cycles.
  - `resp_valid_o` rises at cycle 2·NoHashes+1 (cycle 7 for the defaults).
- Minimum issue interval is 2·NoHashes+2 cycles; a response handshake in RESP allows acceptance the following cycle.
- Outside READ and update-MODIFY cycles, `mem_req_o`=0 and `mem_we_o`=0.
- `req_ready_o` has no combinational path from `req_valid_i`. `resp_valid_o` does not depend on `resp_ready_i`.

## Test plan
All scenarios use the defaults and a zero-initialised 32x4 memory model with 1-cycle read latency.

1. **Lookup on empty memory:** lookup key 0x123 -> exactly 3 reads, 0 writes; `resp_valid_o` at cycle 7 with hit=0, sat=0.
2. **Increment then lookup:** increment 0x123 -> 3 writes to hash_q[0..2], each counter 1 (2 where indices coincide), response hit=0; then lookup 0x123 -> hit=1, sat=0.
3. **Increment saturation:** 16 increments of 0x7FF -> counters reach 15 after the 15th; the 16th responds sat=1 and all three counters remain 15.
4. **Decrement on empty memory:** decrement 0x000 -> writes of 0, response hit=0, sat=1; memory stays all zero.
5. **Response backpressure:** hold `resp_ready_i`=0 for 5 cycles during RESP -> `resp_valid_o`, `resp_hit_o` and `resp_sat_o` stay stable, `req_ready_o`=0 with `req_valid_i` asserted; on release, the new request is accepted one cycle later.
6. **Reset mid-operation:** assert `rst_ni` low during the MODIFY of k=1 of an increment -> all outputs take reset values immediately; only bucket hash_q[0] shows +1; the next lookup completes normally in 7 cycles.

Source files
------------

// File: rtl/hash_bucket_seq.sv
// rtl/hash_bucket_seq.sv - counting-Bloom-filter op sequencer over a single-port counter RAM
package cb_filter_pkg;
  typedef struct packed {
    int unsigned PermuteSeed;
    int unsigned XorSeed;
  } cb_seed_t;
endpackage

// sub_per_hash: keyed rotate/xor rounds over the key, then xor-folded down to HashWidth bits.
module sub_per_hash #(
  parameter int unsigned InpWidth   = 32'd11,
  parameter int unsigned HashWidth  = 32'd5,
  parameter int unsigned NoRounds   = 32'd1,
  parameter int unsigned PermuteKey = 32'd299034753,
  parameter int unsigned XorKey     = 32'd4094834
) (
  input  logic [InpWidth-1:0]  data_i,
  output logic [HashWidth-1:0] hash_o
);
  logic [InpWidth-1:0] stage [NoRounds+1];

  assign stage[0] = data_i;

  for (genvar r = 0; r < NoRounds; r++) begin : g_round
    localparam int unsigned Rot = (PermuteKey + r) % InpWidth;
    localparam logic [InpWidth-1:0] Key = InpWidth'(XorKey >> r);
    logic [2*InpWidth-1:0] dbl;
    // upper half of the doubled word shifted left is a left rotation by Rot
    assign dbl = {stage[r], stage[r]} << Rot;
    assign stage[r+1] = dbl[2*InpWidth-1 -: InpWidth] ^ Key;
  end

  for (genvar j = 0; j < HashWidth; j++) begin : g_fold
    logic bit_x;
    always_comb begin
      bit_x = 1'b0;
      for (int i = j; i < InpWidth; i += HashWidth) bit_x ^= stage[NoRounds][i];
    end
    assign hash_o[j] = bit_x;
  end
endmodule

module hash_bucket_seq #(
  parameter int unsigned DataWidth = 32'd11,
  parameter int unsigned HashWidth = 32'd5,
  parameter int unsigned NoHashes  = 32'd3,
  parameter int unsigned NoRounds  = 32'd1,
  parameter int unsigned CntWidth  = 32'd4,
  parameter cb_filter_pkg::cb_seed_t [NoHashes-1:0] Seeds = '{
    '{PermuteSeed: 32'd299034753, XorSeed: 32'd4094834},
    '{PermuteSeed: 32'd19921030,  XorSeed: 32'd995713},
    '{PermuteSeed: 32'd294388,    XorSeed: 32'd65146511}
  }
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [DataWidth-1:0] req_data_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic                 resp_sat_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [HashWidth-1:0] mem_addr_o,
  output logic [CntWidth-1:0]  mem_wdata_o,
  input  logic [CntWidth-1:0]  mem_rdata_i,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, READ, MODIFY, RESP} state_e;

  localparam int unsigned KW = (NoHashes > 1) ? $clog2(NoHashes) : 1;
  localparam logic [KW-1:0] KLast = KW'(NoHashes - 1);
  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [1:0]             op_q, op_d;
  logic                   hit_q, hit_d, sat_q, sat_d;
  logic [HashWidth-1:0]   hash_c [NoHashes];
  logic [HashWidth-1:0]   hash_q [NoHashes];
  logic [HashWidth-1:0]   hash_d [NoHashes];
  logic                   do_inc, do_dec;

  for (genvar h = 0; h < NoHashes; h++) begin : g_hash
    sub_per_hash #(
      .InpWidth  (DataWidth),
      .HashWidth (HashWidth),
      .NoRounds  (NoRounds),
      .PermuteKey(Seeds[h].PermuteSeed),
      .XorKey    (Seeds[h].XorSeed)
    ) u_hash (
      .data_i(req_data_i),
      .hash_o(hash_c[h])
    );
  end

  // op 2'b11 decodes as neither, so it behaves as a lookup
  assign do_inc = (op_q == 2'b01);
  assign do_dec = (op_q == 2'b10);
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    op_d         = op_q;
    hit_d        = hit_q;
    sat_d        = sat_q;
    hash_d       = hash_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_hit_o   = 1'b0;
    resp_sat_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d    = req_op_i;
          hash_d  = hash_c;
          k_d     = '0;
          hit_d   = 1'b1;
          sat_d   = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = hash_q[k_q];
        state_d    = MODIFY;
      end
      MODIFY: begin
        hit_d = hit_q & (mem_rdata_i != '0);
        if (do_inc || do_dec) begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = hash_q[k_q];
        end
        if (do_inc) begin
          if (mem_rdata_i == CntMax) begin
            mem_wdata_o = mem_rdata_i;
            sat_d       = 1'b1;
          end else begin
            mem_wdata_o = mem_rdata_i + 1'b1;
          end
        end else if (do_dec) begin
          if (mem_rdata_i == '0) begin
            mem_wdata_o = '0;
            sat_d       = 1'b1;
          end else begin
            mem_wdata_o = mem_rdata_i - 1'b1;
          end
        end
        if (k_q == KLast) begin
          state_d = RESP;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = READ;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = hit_q;
        resp_sat_o   = sat_q;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= 2'b00;
      hit_q   <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < NoHashes; i++) hash_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      hit_q   <= hit_d;
      sat_q   <= sat_d;
      hash_q  <= hash_d;
    end
  end
endmodule

// File: tb/tb_hash_bucket_seq.sv
// tb/tb_hash_bucket_seq.sv - scoreboard bench for hash_bucket_seq against a 32x4 RAM model
module tb_hash_bucket_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [10:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit, resp_sat;
  logic        mem_req, mem_we;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  rd_data = '0;
  logic        busy;

  logic [3:0]  mem [32];
  logic [3:0]  exp_mem [32];
  logic        mem_clear = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [1:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;

  int unsigned pseeds [3] = '{32'd294388, 32'd19921030, 32'd299034753};
  int unsigned xseeds [3] = '{32'd65146511, 32'd995713, 32'd4094834};

  always #5 clk = ~clk;

  hash_bucket_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit), .resp_sat_o(resp_sat),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(rd_data), .busy_o(busy)
  );

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_data <= mem[mem_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  function automatic logic [4:0] ref_hash(input int idx, input logic [10:0] key);
    logic [10:0] s, y;
    logic [4:0]  h;
    int unsigned rot;
    s = key;
    y = '0;
    for (int r = 0; r < 1; r++) begin
      rot = (pseeds[idx] + r) % 11;
      for (int i = 0; i < 11; i++) y[(i + rot) % 11] = s[i];
      s = y ^ 11'(xseeds[idx] >> r);
    end
    h = '0;
    for (int i = 0; i < 11; i++) h[i % 5] = h[i % 5] ^ s[i];
    return h;
  endfunction

  function automatic void model_op(input logic [1:0] op, input logic [10:0] key,
                                   output logic hit, output logic sat);
    logic [4:0] h;
    logic [3:0] v;
    hit = 1'b1;
    sat = 1'b0;
    for (int k = 0; k < 3; k++) begin
      h = ref_hash(k, key);
      v = exp_mem[h];
      if (v == 4'd0) hit = 1'b0;
      if (op == 2'b01) begin
        if (v == 4'd15) sat = 1'b1; else exp_mem[h] = v + 4'd1;
      end else if (op == 2'b10) begin
        if (v == 4'd0) sat = 1'b1; else exp_mem[h] = v - 4'd1;
      end
    end
  endfunction

  task automatic clear_mem();
    mem_clear = 1'b1;
    @(posedge clk); #1;
    mem_clear = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
  endtask

  // Leaves the bench 1 time unit after the accepting edge (cycle 1 of the op).
  task automatic start_req(input logic [1:0] op, input logic [10:0] key, input bit push);
    logic h, s;
    int n;
    if (push) begin
      model_op(op, key, h, s);
      exp_q.push_back({h, s});
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = key;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b required=1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout: resp_valid=%b required=1", resp_valid);
    end
  endtask

  task automatic collect_resp(input string name);
    logic [1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: got hit/sat=%b required none", name, {resp_hit, resp_sat});
    end else begin
      e = exp_q.pop_front();
      if ({resp_hit, resp_sat} !== e) begin
        bad++;
        $display("FAIL %s_resp: hit/sat=%b required=%b", name, {resp_hit, resp_sat}, e);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready, resp_valid, resp_hit, resp_sat, mem_req, mem_we, busy, mem_addr, mem_wdata}
        !== {1'b1, 6'b0, 5'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b hit=%b sat=%b mreq=%b we=%b busy=%b addr=%0d wd=%0d required rdy=1 rest 0",
               req_ready, resp_valid, resp_hit, resp_sat, mem_req, mem_we, busy, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    clear_mem();
  endtask

  task automatic test_lookup_empty();
    int r0, w0, lat;
    r0 = rd_cnt; w0 = wr_cnt;
    start_req(2'b00, 11'h123, 1'b1);
    wait_resp(lat);
    total++;
    if (lat !== 7) begin bad++; $display("FAIL lookup_latency: %0d required=7", lat); end
    collect_resp("lookup_empty");
    total++;
    if ((rd_cnt - r0) !== 3 || (wr_cnt - w0) !== 0) begin
      bad++;
      $display("FAIL lookup_accesses: reads=%0d writes=%0d required 3/0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_inc_then_lookup();
    int w0, lat;
    logic [4:0] h;
    w0 = wr_cnt;
    start_req(2'b01, 11'h123, 1'b1);
    wait_resp(lat);
    collect_resp("inc");
    total++;
    if ((wr_cnt - w0) !== 3) begin bad++; $display("FAIL inc_writes: %0d required=3", wr_cnt - w0); end
    for (int k = 0; k < 3; k++) begin
      h = ref_hash(k, 11'h123);
      total++;
      if (mem[h] !== exp_mem[h]) begin
        bad++;
        $display("FAIL inc_bucket%0d: mem[%0d]=%0d required=%0d", k, h, mem[h], exp_mem[h]);
      end
    end
    start_req(2'b00, 11'h123, 1'b1);
    wait_resp(lat);
    collect_resp("lookup_after_inc");
  endtask

  task automatic test_inc_sat();
    int lat;
    logic [4:0] h;
    clear_mem();
    for (int n = 0; n < 16; n++) begin
      start_req(2'b01, 11'h7FF, 1'b1);
      wait_resp(lat);
      collect_resp($sformatf("sat_inc%0d", n));
    end
    for (int k = 0; k < 3; k++) begin
      h = ref_hash(k, 11'h7FF);
      total++;
      if (mem[h] !== 4'd15) begin
        bad++;
        $display("FAIL sat_bucket%0d: mem[%0d]=%0d required=15", k, h, mem[h]);
      end
    end
  endtask

  task automatic test_dec_empty();
    int w0, lat, nz;
    clear_mem();
    w0 = wr_cnt;
    start_req(2'b10, 11'h000, 1'b1);
    wait_resp(lat);
    collect_resp("dec_empty");
    total++;
    if ((wr_cnt - w0) !== 3) begin bad++; $display("FAIL dec_writes: %0d required=3", wr_cnt - w0); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== 4'd0) nz++;
    total++;
    if (nz !== 0) begin bad++; $display("FAIL dec_mem_zero: nonzero=%0d required=0", nz); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic h, s;
    logic [1:0] e;
    resp_ready = 1'b0;
    start_req(2'b01, 11'h2A5, 1'b1);
    wait_resp(lat);
    e = exp_q[0];
    model_op(2'b00, 11'h2A5, h, s);
    exp_q.push_back({h, s});
    req_valid = 1'b1; req_op = 2'b00; req_data = 11'h2A5;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({resp_valid, req_ready, resp_hit, resp_sat} !== {2'b10, e}) begin
        bad++;
        $display("FAIL bp_hold%0d: rv=%b rdy=%b hit/sat=%b%b required rv=1 rdy=0 hit/sat=%b",
                 c, resp_valid, req_ready, resp_hit, resp_sat, e);
      end
    end
    collect_resp("bp_first");
    total++;
    if ({req_ready, busy} !== 2'b10) begin
      bad++; $display("FAIL bp_idle: rdy=%b busy=%b required 1/0", req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if ({busy, mem_req, mem_we} !== 3'b110) begin
      bad++; $display("FAIL bp_accept: busy=%b mreq=%b we=%b required 1/1/0", busy, mem_req, mem_we);
    end
    wait_resp(lat);
    total++;
    if (lat !== 7) begin bad++; $display("FAIL bp_latency: %0d required=7", lat); end
    collect_resp("bp_second");
  endtask

  task automatic test_reset_mid_op();
    int lat, diffs;
    logic [4:0] h0;
    clear_mem();
    h0 = ref_hash(0, 11'h055);
    start_req(2'b01, 11'h055, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_hit, resp_sat, mem_req, mem_we, busy, mem_addr, mem_wdata}
        !== {1'b1, 6'b0, 5'd0, 4'd0}) begin
      bad++;
      $display("FAIL midreset_outputs: rdy=%b rv=%b mreq=%b we=%b busy=%b addr=%0d wd=%0d required rdy=1 rest 0",
               req_ready, resp_valid, mem_req, mem_we, busy, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_mem[h0] = 4'd1;
    diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) diffs++;
    total++;
    if (diffs !== 0 || mem[h0] !== 4'd1) begin
      bad++; $display("FAIL midreset_mem: diffs=%0d mem[h0]=%0d required 0/1", diffs, mem[h0]);
    end
    start_req(2'b00, 11'h055, 1'b1);
    wait_resp(lat);
    total++;
    if (lat !== 7) begin bad++; $display("FAIL midreset_latency: %0d required=7", lat); end
    collect_resp("midreset_lookup");
  endtask

  initial begin
    test_reset();
    test_lookup_empty();
    test_inc_then_lookup();
    test_inc_sat();
    test_dec_empty();
    test_backpressure();
    test_reset_mid_op();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: %0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
